// File: rtl/dither_pkg.sv
// Shared types and helpers for the dither lock channel: phase encoding and
// symmetric saturation used by the demodulator and the integrator.
package dither_pkg;

  typedef enum logic {
    PH_POS = 1'b0,
    PH_NEG = 1'b1
  } phase_e;

  // Clamp to the symmetric range [-(2^(width-1)-1), 2^(width-1)-1]
  function automatic logic signed [63:0] sat_n(input logic signed [63:0] value,
                                               input int width);
    logic signed [63:0] lim;
    lim = (64'sd1 <<< (width - 1)) - 64'sd1;
    if (value > lim) return lim;
    if (value < -lim) return -lim;
    return value;
  endfunction

endpackage

// File: rtl/dither_lock_demod_nco.sv
// Half-period phase counter producing the square dither, the cycle-start
// trigger and demodulator strobes, all registered and aligned to dith_o.
module dither_nco
  import dither_pkg::*;
#(
  parameter int N_B    = 16,
  parameter int N_HALF = 500,
  parameter int N_SKIP = 50,
  parameter int AMP    = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic signed [N_B-1:0] dith_o,
  output logic               inhtrig_o,
  output logic               samp_en_o,
  output phase_e             ph_o,
  output logic               cyc_end_o
);

  localparam int CNT_W = $clog2(N_HALF);
  localparam logic signed [N_B-1:0] AMP_P = N_B'(AMP);
  localparam logic signed [N_B-1:0] AMP_N = -AMP_P;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  phase_e           ph_q, ph_d;
  logic signed [N_B-1:0] dith_q;
  logic             trig_q, sampEn_q, cycEnd_q;
  phase_e           phOut_q;
  logic             lastCnt, skipOk;

  assign lastCnt = (cnt_q == CNT_W'(N_HALF - 1));

  generate
    if (N_SKIP == 0) begin : g_noskip
      assign skipOk = 1'b1;
    end else begin : g_skip
      assign skipOk = (cnt_q >= CNT_W'(N_SKIP));
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    ph_d  = ph_q;
    if (lastCnt) begin
      cnt_d = '0;
      ph_d  = (ph_q == PH_POS) ? PH_NEG : PH_POS;
    end
  end

  // Strobes carry the pre-edge state so each sample pairs with the dither level shown
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      ph_q     <= PH_POS;
      dith_q   <= '0;
      trig_q   <= 1'b0;
      sampEn_q <= 1'b0;
      phOut_q  <= PH_POS;
      cycEnd_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ph_q     <= ph_d;
      dith_q   <= (ph_q == PH_POS) ? AMP_P : AMP_N;
      trig_q   <= (cnt_q == '0) && (ph_q == PH_POS);
      sampEn_q <= skipOk;
      phOut_q  <= ph_q;
      cycEnd_q <= lastCnt && (ph_q == PH_NEG);
    end
  end

  assign dith_o    = dith_q;
  assign inhtrig_o = trig_q;
  assign samp_en_o = sampEn_q;
  assign ph_o      = phOut_q;
  assign cyc_end_o = cycEnd_q;

endmodule

// File: rtl/dither_lock_demod.sv
// Lock-in servo for one dither channel: synchronous demodulation of sig_in
// per dither cycle and a holdable, clamped integrator driving lock_out.
module dither_lock_demod
  import dither_pkg::*;
#(
  parameter int N_B    = 16,
  parameter int N_OUT  = 16,
  parameter int N_ACC  = 32,
  parameter int N_HALF = 500,
  parameter int N_SKIP = 50,
  parameter int AMP    = 1024,
  parameter int ERR_SH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [N_B-1:0]   sig_in,
  input  logic                    inthld,
  output logic signed [N_B-1:0]   dith_out,
  output logic                    inhtrig,
  output logic signed [N_B-1:0]   err_out,
  output logic                    err_valid,
  output logic signed [N_OUT-1:0] lock_out,
  output logic                    sat
);

  localparam logic signed [N_OUT-1:0] OUT_MAX = N_OUT'((64'sd1 <<< (N_OUT - 1)) - 64'sd1);

  logic   sampEn, cycEnd;
  phase_e samplePh;

  logic signed [N_ACC-1:0] acc_q, acc_d, accNext, sigExt;
  logic signed [N_B-1:0]   err_q, err_d;
  logic                    errValid_q, errValid_d;
  logic signed [N_OUT-1:0] integ_q, integ_d, lock_q;
  logic                    sat_q;
  logic signed [63:0]      accWide, sumWide;

  dither_nco #(
    .N_B(N_B), .N_HALF(N_HALF), .N_SKIP(N_SKIP), .AMP(AMP)
  ) u_nco (
    .clk_i(clk), .rst_i(rst),
    .dith_o(dith_out), .inhtrig_o(inhtrig),
    .samp_en_o(sampEn), .ph_o(samplePh), .cyc_end_o(cycEnd)
  );

  assign sigExt = {{(N_ACC - N_B){sig_in[N_B-1]}}, sig_in};

  // The closing sample of a cycle is folded in before err_out is formed
  always_comb begin
    acc_d      = acc_q;
    err_d      = err_q;
    errValid_d = 1'b0;
    integ_d    = integ_q;
    accNext    = acc_q;
    accWide    = '0;
    sumWide    = '0;
    if (sampEn)
      accNext = (samplePh == PH_POS) ? acc_q + sigExt : acc_q - sigExt;
    if (cycEnd) begin
      accWide    = {{(64 - N_ACC){accNext[N_ACC-1]}}, accNext};
      err_d      = N_B'(sat_n(accWide >>> ERR_SH, N_B));
      errValid_d = 1'b1;
      acc_d      = '0;
    end else begin
      acc_d = accNext;
    end
    if (errValid_q && !inthld) begin
      sumWide = {{(64 - N_OUT){integ_q[N_OUT-1]}}, integ_q}
              + {{(64 - N_B){err_q[N_B-1]}}, err_q};
      integ_d = N_OUT'(sat_n(sumWide, N_OUT));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      err_q      <= '0;
      errValid_q <= 1'b0;
      integ_q    <= '0;
      lock_q     <= '0;
      sat_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      err_q      <= err_d;
      errValid_q <= errValid_d;
      integ_q    <= integ_d;
      lock_q     <= integ_q;
      sat_q      <= (integ_q == OUT_MAX) || (integ_q == -OUT_MAX);
    end
  end

  assign err_out   = err_q;
  assign err_valid = errValid_q;
  assign lock_out  = lock_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_dither_lock_demod.sv
// Self-checking bench for dither_lock_demod with an edge-indexed behavioural
// model of the dither, per-cycle demodulation and the clamped integrator.
module tb_dither_lock_demod;

  localparam int HALF = 8;
  localparam int SKIP = 2;
  localparam int AMPV = 100;
  localparam int SHV  = 0;
  localparam longint LIM = 32767;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] sig_in = '0;
  logic inthld = 1'b0;
  logic signed [15:0] dith_out, err_out, lock_out;
  logic inhtrig, err_valid, sat;

  dither_lock_demod #(
    .N_B(16), .N_OUT(16), .N_ACC(32), .N_HALF(HALF),
    .N_SKIP(SKIP), .AMP(AMPV), .ERR_SH(SHV)
  ) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .inthld(inthld),
    .dith_out(dith_out), .inhtrig(inhtrig), .err_out(err_out),
    .err_valid(err_valid), .lock_out(lock_out), .sat(sat)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nFail = 0;
  int edgeN = 0;
  longint mAcc = 0;
  longint mInteg = 0;
  logic signed [15:0] eDith = '0, eErr = '0, eLock = '0;
  logic eTrig = 1'b0, eValid = 1'b0, eSat = 1'b0;

  function automatic longint clampSym(input longint v, input longint lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  // Edge 1 is the first edge after reset release; a cycle spans 2*HALF edges
  task automatic modelEdge(input logic signed [15:0] s, input logic h, input logic r);
    int pos;
    longint prevInteg;
    if (r) begin
      edgeN = 0; mAcc = 0; mInteg = 0;
      eDith = '0; eErr = '0; eLock = '0; eTrig = 0; eValid = 0; eSat = 0;
      return;
    end
    edgeN++;
    prevInteg = mInteg;
    if (eValid && !h) mInteg = clampSym(mInteg + longint'(eErr), LIM);
    eLock = 16'(prevInteg);
    eSat  = (prevInteg == LIM) || (prevInteg == -LIM);
    eValid = 1'b0;
    if (edgeN >= 2) begin
      pos = (edgeN - 2) % (2 * HALF);
      if ((pos % HALF) >= SKIP) mAcc += (pos < HALF) ? longint'(s) : -longint'(s);
      if (pos == 2 * HALF - 1) begin
        eErr = 16'(clampSym(mAcc >>> SHV, LIM));
        eValid = 1'b1;
        mAcc = 0;
      end
    end
    pos = (edgeN - 1) % (2 * HALF);
    eDith = (pos < HALF) ? 16'(AMPV) : -16'(AMPV);
    eTrig = (pos == 0);
  endtask

  task automatic checkOutput();
    nVec++;
    assert (dith_out === eDith) else begin
      nFail++; $error("[TB] FAIL dith_out e%0d got %0d want %0d", edgeN, dith_out, eDith);
    end
    nVec++;
    assert (inhtrig === eTrig) else begin
      nFail++; $error("[TB] FAIL inhtrig e%0d got %0b want %0b", edgeN, inhtrig, eTrig);
    end
    nVec++;
    assert (err_out === eErr) else begin
      nFail++; $error("[TB] FAIL err_out e%0d got %0d want %0d", edgeN, err_out, eErr);
    end
    nVec++;
    assert (err_valid === eValid) else begin
      nFail++; $error("[TB] FAIL err_valid e%0d got %0b want %0b", edgeN, err_valid, eValid);
    end
    nVec++;
    assert (lock_out === eLock) else begin
      nFail++; $error("[TB] FAIL lock_out e%0d got %0d want %0d", edgeN, lock_out, eLock);
    end
    nVec++;
    assert (sat === eSat) else begin
      nFail++; $error("[TB] FAIL sat e%0d got %0b want %0b", edgeN, sat, eSat);
    end
  endtask

  task automatic applyStimulus(input logic signed [15:0] s, input logic h, input logic r);
    sig_in = s;
    inthld = h;
    rst    = r;
    @(posedge clk);
    #1;
    modelEdge(s, h, r);
    checkOutput();
  endtask

  function automatic logic signed [15:0] randSig(input int span);
    return 16'(int'($urandom_range(2 * span, 0)) - span);
  endfunction

  initial begin
    $display("[TB] reset state and dither timing with constant input");
    applyStimulus(16'sd0, 1'b0, 1'b1);
    for (int i = 0; i < 48; i++) applyStimulus(16'sd50, 1'b0, 1'b0);

    $display("[TB] in-phase signal, integrator ramps");
    applyStimulus(16'sd0, 1'b0, 1'b1);
    for (int i = 0; i < 52; i++) begin
      applyStimulus((eDith > 0) ? 16'sd50 : -16'sd50, 1'b0, 1'b0);
      if (edgeN == 19 || edgeN == 35 || edgeN == 51) begin
        nVec++;
        assert (lock_out === 16'(600 * ((edgeN - 3) / 16))) else begin
          nFail++; $error("[TB] FAIL ramp e%0d got %0d want %0d", edgeN, lock_out, 600 * ((edgeN - 3) / 16));
        end
      end
    end

    $display("[TB] integrator hold from edge 20, then random hold toggling");
    applyStimulus(16'sd0, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++)
      applyStimulus((eDith > 0) ? 16'sd50 : -16'sd50, (edgeN + 1 >= 20), 1'b0);
    nVec++;
    assert (lock_out === 16'sd600) else begin
      nFail++; $error("[TB] FAIL hold got %0d want 600", lock_out);
    end
    for (int i = 0; i < 96; i++)
      applyStimulus((eDith > 0) ? 16'sd50 : -16'sd50, 1'($urandom_range(1, 0)), 1'b0);

    $display("[TB] full-scale signal saturates then reverses");
    applyStimulus(16'sd0, 1'b0, 1'b1);
    for (int i = 0; i < 56; i++)
      applyStimulus((eDith > 0) ? 16'sd32767 : -16'sd32767, 1'b0, 1'b0);
    nVec++;
    assert (sat === 1'b1 && lock_out === 16'sd32767) else begin
      nFail++; $error("[TB] FAIL clamp got %0d/%0b want 32767/1", lock_out, sat);
    end
    for (int i = 0; i < 64; i++)
      applyStimulus((eDith > 0) ? -16'sd32767 : 16'sd32767, 1'b0, 1'b0);

    $display("[TB] random signal and hold");
    for (int i = 0; i < 128; i++)
      applyStimulus(randSig(2000), 1'($urandom_range(1, 0)), 1'b0);

    $display("[TB] reset mid-cycle with accumulator loaded");
    applyStimulus(16'sd0, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) applyStimulus(16'sd3000, 1'b0, 1'b0);
    applyStimulus(16'sd3000, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++)
      applyStimulus(randSig(1500), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
